// File: rtl/mixed_cmd_scheduler.sv
// Two-requester command scheduler. Requesters are arbitrated round-robin and
// one command runs at a time against an external single-port memory. A valid
// bit is kept per entry, and every accepted command gets one tagged response.
module mixed_cmd_scheduler #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int TAGW  = 9,
  parameter int WAITW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [2*TAGW-1:0] req_tag,
  input  logic [2*AW-1:0]   req_index,
  input  logic [2*DW-1:0]   req_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAGW-1:0]   rsp_tag,
  output logic [DW-1:0]     rsp_data,
  output logic [1:0]        rsp_status,
  output logic              busy
);

  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_WAIT  = 3'd2,
    OP_EVICT = 3'd3,
    OP_TRIM  = 3'd4
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_ISSUE, ST_RD_CAP, ST_EV_WR, ST_WR, ST_WAIT, ST_RESP
  } state_e;

  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_MISS    = 2'd1;
  localparam logic [1:0] STAT_ILLEGAL = 2'd2;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              last_grant_q, last_grant_d;
  logic [WAITW-1:0]  cnt_q, cnt_d;
  logic              id_q, id_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [AW-1:0]     index_q, index_d;
  logic [DW-1:0]     data_q, data_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic [1:0]        status_q, status_d;

  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic [2:0]        sel_opcode;
  logic [TAGW-1:0]   sel_tag;
  logic [AW-1:0]     sel_index;
  logic [DW-1:0]     sel_data;

  // Round-robin grant: on a tie the requester that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE) ? grant : 2'b00;
  assign accept     = |(req_valid & req_ready);
  assign sel        = grant[1];
  assign sel_opcode = sel ? req_opcode[5:3] : req_opcode[2:0];
  assign sel_tag    = sel ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
  assign sel_index  = sel ? req_index[2*AW-1:AW] : req_index[AW-1:0];
  assign sel_data   = sel ? req_data[2*DW-1:DW] : req_data[DW-1:0];

  // Next-state logic, memory strobes, and command/valid-bit bookkeeping.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    opcode_d     = opcode_q;
    tag_d        = tag_q;
    index_d      = index_q;
    data_d       = data_q;
    rsp_data_d   = rsp_data_q;
    status_d     = status_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d         = sel;
          opcode_d     = sel_opcode;
          tag_d        = sel_tag;
          index_d      = sel_index;
          data_d       = sel_data;
          last_grant_d = sel;
          rsp_data_d   = '0;
          status_d     = STAT_OK;
          cnt_d        = '0;
          case (sel_opcode)
            OP_READ, OP_EVICT: begin
              if (valid_q[sel_index]) begin
                state_d = ST_RD_ISSUE;
              end else begin
                status_d = STAT_MISS;
                state_d  = ST_RESP;
              end
            end
            OP_WRITE: state_d = ST_WR;
            OP_WAIT: begin
              cnt_d   = sel_data[WAITW-1:0];
              state_d = (sel_data[WAITW-1:0] == '0) ? ST_RESP : ST_WAIT;
            end
            OP_TRIM: begin
              valid_d[sel_index] = 1'b0;
              state_d            = ST_RESP;
            end
            default: begin
              status_d = STAT_ILLEGAL;
              state_d  = ST_RESP;
            end
          endcase
        end
      end
      ST_RD_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = index_q;
        state_d  = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        rsp_data_d = mem_rdata;
        state_d    = (opcode_q == OP_EVICT) ? ST_EV_WR : ST_RESP;
      end
      ST_EV_WR: begin
        mem_en           = 1'b1;
        mem_we           = 1'b1;
        mem_addr         = index_q;
        valid_d[index_q] = 1'b0;
        state_d          = ST_RESP;
      end
      ST_WR: begin
        mem_en           = 1'b1;
        mem_we           = 1'b1;
        mem_addr         = index_q;
        mem_wdata        = data_q;
        valid_d[index_q] = 1'b1;
        state_d          = ST_RESP;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAITW'(1) || cnt_q == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and command registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      opcode_q     <= '0;
      tag_q        <= '0;
      index_q      <= '0;
      data_q       <= '0;
      rsp_data_q   <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      opcode_q     <= opcode_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      data_q       <= data_d;
      rsp_data_q   <= rsp_data_d;
      status_q     <= status_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rsp_valid & id_q;
  assign rsp_tag    = rsp_valid ? tag_q : '0;
  assign rsp_data   = rsp_valid ? rsp_data_q : '0;
  assign rsp_status = rsp_valid ? status_q : 2'b00;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mixed_cmd_scheduler.sv
// Directed testbench for mixed_cmd_scheduler with a behavioural memory model.
module tb_mixed_cmd_scheduler;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TAGW = 9;
  localparam logic [2:0] OP_READ = 3'd0, OP_WRITE = 3'd1, OP_WAIT = 3'd2,
                         OP_EVICT = 3'd3, OP_TRIM = 3'd4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [5:0]        req_opcode = '0;
  logic [2*TAGW-1:0] req_tag = '0;
  logic [2*AW-1:0]   req_index = '0;
  logic [2*DW-1:0]   req_data = '0;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic              rsp_id;
  logic [TAGW-1:0]   rsp_tag;
  logic [DW-1:0]     rsp_data;
  logic [1:0]        rsp_status;
  logic              busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int mem_en_cnt = 0;
  int last_wr_cyc = -1;
  logic [DW-1:0] last_wr_data = '0;
  logic [DW-1:0] mem [16];

  mixed_cmd_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_tag(req_tag), .req_index(req_index), .req_data(req_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter plus single-port memory model that logs the last write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      mem_en_cnt <= mem_en_cnt + 1;
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        last_wr_cyc   <= cyc;
        last_wr_data  <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic send(input int r, input logic [2:0] op, input logic [TAGW-1:0] tag,
                      input logic [AW-1:0] idx, input logic [DW-1:0] d, output int acc);
    acc = -1;
    req_opcode[r*3 +: 3]       = op;
    req_tag[r*TAGW +: TAGW]    = tag;
    req_index[r*AW +: AW]      = idx;
    req_data[r*DW +: DW]       = d;
    req_valid[r]               = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (req_ready[r]) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL send_timeout: req_ready[%0d] got 0 required 1", r);
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, output int lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      if (rsp_valid) begin
        lat = cyc - acc;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL rsp_timeout: rsp_valid got 0 required 1");
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_id, rsp_tag,
         rsp_data, rsp_status, busy} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: busy=%0d rsp_valid=%0d mem_en=%0d req_ready=%b required all 0",
               busy, rsp_valid, mem_en, req_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, rsp_valid, mem_en, req_ready} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: busy=%0d rsp_valid=%0d mem_en=%0d req_ready=%b required 0",
               busy, rsp_valid, mem_en, req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int acc, lat;
    send(0, OP_WRITE, 9'h011, 4'd3, 32'hDEADBEEF, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("[TB] FAIL wr_latency: got %0d required 2", lat); end
    n_cmp++;
    if ({rsp_id, rsp_tag, rsp_status, rsp_data} !== {1'b0, 9'h011, 2'd0, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL wr_rsp: id=%0d tag=%h st=%0d data=%h required 0/011/0/0",
               rsp_id, rsp_tag, rsp_status, rsp_data);
    end
    n_cmp++;
    if (last_wr_cyc !== acc + 1 || last_wr_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL wr_mem: cycle %0d data %h required %0d DEADBEEF", last_wr_cyc, last_wr_data, acc + 1);
    end
    @(negedge clk);
    send(0, OP_READ, 9'h012, 4'd3, 32'h0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("[TB] FAIL rd_latency: got %0d required 3", lat); end
    n_cmp++;
    if ({rsp_id, rsp_tag, rsp_status, rsp_data} !== {1'b0, 9'h012, 2'd0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("[TB] FAIL rd_rsp: id=%0d tag=%h st=%0d data=%h required 0/012/0/DEADBEEF",
               rsp_id, rsp_tag, rsp_status, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_miss_trim();
    int acc, lat, en0;
    en0 = mem_en_cnt;
    send(0, OP_READ, 9'h020, 4'd7, 32'h0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if (lat !== 1) begin n_fail++; $display("[TB] FAIL miss_latency: got %0d required 1", lat); end
    n_cmp++;
    if ({rsp_status, rsp_data, rsp_tag} !== {2'd1, 32'h0, 9'h020}) begin
      n_fail++;
      $display("[TB] FAIL miss_rsp: st=%0d data=%h tag=%h required 1/0/020", rsp_status, rsp_data, rsp_tag);
    end
    n_cmp++;
    if (mem_en_cnt !== en0) begin
      n_fail++; $display("[TB] FAIL miss_no_mem: mem_en count %0d required %0d", mem_en_cnt, en0);
    end
    @(negedge clk);
    send(1, OP_TRIM, 9'h021, 4'd3, 32'h0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if ({lat == 1, rsp_status, rsp_id} !== {1'b1, 2'd0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL trim_rsp: lat=%0d st=%0d id=%0d required 1/0/1", lat, rsp_status, rsp_id);
    end
    @(negedge clk);
    send(0, OP_READ, 9'h022, 4'd3, 32'h0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if ({lat == 1, rsp_status, rsp_data} !== {1'b1, 2'd1, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL read_after_trim: lat=%0d st=%0d data=%h required 1/1/0", lat, rsp_status, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_illegal();
    int acc, lat;
    send(0, OP_WAIT, 9'h030, 4'd0, 32'd5, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if (lat !== 6 || rsp_status !== 2'd0) begin
      n_fail++; $display("[TB] FAIL wait5: lat=%0d st=%0d required 6/0", lat, rsp_status);
    end
    @(negedge clk);
    send(1, OP_WAIT, 9'h031, 4'd0, 32'd0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if (lat !== 1 || rsp_tag !== 9'h031) begin
      n_fail++; $display("[TB] FAIL wait0: lat=%0d tag=%h required 1/031", lat, rsp_tag);
    end
    @(negedge clk);
    send(0, 3'd6, 9'h032, 4'd1, 32'h0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if (lat !== 1 || rsp_status !== 2'd2) begin
      n_fail++; $display("[TB] FAIL illegal_op: lat=%0d st=%0d required 1/2", lat, rsp_status);
    end
    @(negedge clk);
  endtask

  task automatic test_evict();
    int acc, lat;
    send(0, OP_WRITE, 9'h040, 4'd3, 32'h12345678, acc);
    wait_rsp(acc, lat);
    @(negedge clk);
    send(0, OP_EVICT, 9'h041, 4'd3, 32'h0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("[TB] FAIL evict_latency: got %0d required 4", lat); end
    n_cmp++;
    if ({rsp_status, rsp_data, rsp_tag} !== {2'd0, 32'h12345678, 9'h041}) begin
      n_fail++;
      $display("[TB] FAIL evict_rsp: st=%0d data=%h tag=%h required 0/12345678/041", rsp_status, rsp_data, rsp_tag);
    end
    n_cmp++;
    if (last_wr_cyc !== acc + 3 || last_wr_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL evict_mem: cycle %0d data %h required %0d 0", last_wr_cyc, last_wr_data, acc + 3);
    end
    @(negedge clk);
    send(1, OP_READ, 9'h042, 4'd3, 32'h0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if (rsp_status !== 2'd1 || lat !== 1) begin
      n_fail++; $display("[TB] FAIL read_after_evict: st=%0d lat=%0d required 1/1", rsp_status, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int g, r;
    do_reset();
    req_opcode = {OP_WAIT, OP_WAIT};
    req_tag    = {9'h101, 9'h100};
    req_data   = '0;
    req_valid  = 2'b11;
    g = 0;
    r = 0;
    for (int n = 0; n < 40 && (g < 4 || r < 4); n++) begin
      #1;
      if (req_ready != 2'b00 && g < 4) begin
        n_cmp++;
        if (req_ready !== ((g % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("[TB] FAIL rr_grant%0d: got %b required %b", g, req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
        end
        g++;
      end
      if (rsp_valid && r < 4) begin
        n_cmp++;
        if (rsp_id !== (r % 2 == 1)) begin
          n_fail++; $display("[TB] FAIL rr_rsp_id%0d: got %0d required %0d", r, rsp_id, r % 2);
        end
        r++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    if (g < 4 || r < 4) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL rr_timeout: grants %0d responses %0d required 4/4", g, r);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int acc, lat;
    send(0, OP_WRITE, 9'h055, 4'd5, 32'hA5A5A5A5, acc);
    wait_rsp(acc, lat);
    @(negedge clk);
    rsp_ready = 1'b0;
    send(0, OP_TRIM, 9'h056, 4'd6, 32'h0, acc);
    wait_rsp(acc, lat);
    req_opcode[5:3] = OP_READ;
    req_tag[17:9]   = 9'h1AA;
    req_index[7:4]  = 4'd5;
    req_valid[1]    = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_tag, rsp_status, rsp_data, req_ready} !==
          {1'b1, 1'b0, 9'h056, 2'd0, 32'h0, 2'b00}) begin
        n_fail++;
        $display("[TB] FAIL bp_stall%0d: valid=%0d tag=%h st=%0d req_ready=%b required 1/056/0/00",
                 n, rsp_valid, rsp_tag, rsp_status, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    send(1, OP_READ, 9'h1AA, 4'd5, 32'h0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if ({lat == 3, rsp_id, rsp_tag, rsp_data} !== {1'b1, 1'b1, 9'h1AA, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("[TB] FAIL bp_release: lat=%0d id=%0d tag=%h data=%h required 3/1/1AA/A5A5A5A5",
               lat, rsp_id, rsp_tag, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int acc, lat, en0;
    send(0, OP_WRITE, 9'h060, 4'd9, 32'hCAFEF00D, acc);
    wait_rsp(acc, lat);
    @(negedge clk);
    send(0, OP_READ, 9'h061, 4'd9, 32'h0, acc);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_id, rsp_tag,
         rsp_data, rsp_status, busy} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midop_reset_outputs: busy=%0d rsp_valid=%0d mem_en=%0d required 0",
               busy, rsp_valid, mem_en);
    end
    en0 = mem_en_cnt;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1;
      n_cmp++;
      if ({rsp_valid, mem_en, busy} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL midop_quiet%0d: rsp_valid=%0d mem_en=%0d busy=%0d required 0", n, rsp_valid, mem_en, busy);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (mem_en_cnt !== en0) begin
      n_fail++; $display("[TB] FAIL midop_no_mem: mem_en count %0d required %0d", mem_en_cnt, en0);
    end
    send(1, OP_WRITE, 9'h062, 4'd9, 32'h0BADF00D, acc);
    wait_rsp(acc, lat);
    @(negedge clk);
    send(0, OP_READ, 9'h063, 4'd9, 32'h0, acc);
    wait_rsp(acc, lat);
    n_cmp++;
    if ({lat == 3, rsp_status, rsp_tag, rsp_data} !== {1'b1, 2'd0, 9'h063, 32'h0BADF00D}) begin
      n_fail++;
      $display("[TB] FAIL midop_recover: lat=%0d st=%0d tag=%h data=%h required 3/0/063/0BADF00D",
               lat, rsp_status, rsp_tag, rsp_data);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_miss_trim();
    test_wait_illegal();
    test_evict();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
